// File: rtl/grant_dec_pkg.sv
// Shared types and defaults for the grant decoder path.
package grant_dec_pkg;

    localparam int unsigned DEF_W       = 3;
    localparam int unsigned DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    // Timeout counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder, W in, 2**W out.
module onehot_dec #(
    parameter  int unsigned W = 3,
    localparam int unsigned N = 1 << W
) (
    input  logic [W-1:0] i_code,
    output logic [N-1:0] o_onehot
);

    always_comb begin
        o_onehot         = '0;
        o_onehot[i_code] = 1'b1;
    end

endmodule

// File: rtl/grant_decoder_3to8.sv
// Sequential 3-to-8 grant decoder: holds a one-hot grant until completion,
// abort or timeout, with a guard cycle between grants.
module grant_decoder_3to8
    import grant_dec_pkg::*;
#(
    parameter  int unsigned W       = DEF_W,
    localparam int unsigned N       = 1 << W,
    parameter  int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         code_valid,
    input  logic [W-1:0] code,
    output logic         code_ready,
    output logic [N-1:0] y,
    input  logic [N-1:0] done,
    output logic         busy,
    output logic         err
);

    localparam int unsigned CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e         r_state;
    logic [N-1:0]   r_y;
    logic           r_err;
    logic [W-1:0]   r_code;
    logic [CW-1:0]  r_cnt;

    logic [N-1:0]   w_dec;
    logic           w_accept;
    logic           w_hit;
    logic           w_stray;
    logic           w_timeout;

    onehot_dec #(
        .W (W)
    ) u_dec (
        .i_code   (code),
        .o_onehot (w_dec)
    );

    assign code_ready = en && (r_state == StIdle);
    assign busy       = (r_state != StIdle);
    assign y          = r_y;
    assign err        = r_err;

    assign w_accept  = code_valid && code_ready;
    assign w_hit     = done[r_code];
    // In GRANT r_y is exactly the decoded r_code, so it masks off the valid bit.
    assign w_stray   = |(done & ~r_y);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_y     <= '0;
            r_err   <= 1'b0;
            r_code  <= '0;
            r_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_code  <= code;
                        r_y     <= w_dec;
                        r_cnt   <= '0;
                        r_state <= StGrant;
                    end
                end
                StGrant: begin
                    r_err <= w_stray;
                    if (w_hit) begin
                        r_y     <= '0;
                        r_state <= StRelease;
                    end else if (!en) begin
                        r_y     <= '0;
                        r_state <= StIdle;
                    end else if (w_timeout) begin
                        r_y     <= '0;
                        r_err   <= 1'b1;
                        r_state <= StRelease;
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StRelease: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_decoder_3to8.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_grant_decoder_3to8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       code_valid;
    logic [2:0] code;
    logic       code_ready;
    logic [7:0] y;
    logic [7:0] done;
    logic       busy;
    logic       err;

    typedef struct {
        int         cyc;
        logic [7:0] y;
        logic       err;
        logic       busy;
        logic       rdy;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    grant_decoder_3to8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .code_valid (code_valid),
        .code       (code),
        .code_ready (code_ready),
        .y          (y),
        .done       (done),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y))
        else $error("y multi-hot: %b", y);

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (y != 8'h00) begin
            total++;
            if (!$onehot(y)) begin
                bad++;
                $display("FAIL onehot cyc=%0d: got y=%b, want one-hot", cyc, y);
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc != cyc || {y, err, busy, code_ready} !== {e.y, e.err, e.busy, e.rdy}) begin
                bad++;
                $display("FAIL %s cyc=%0d(exp %0d): got y=%h err=%b busy=%b rdy=%b, want y=%h err=%b busy=%b rdy=%b",
                         e.name, cyc, e.cyc, y, err, busy, code_ready, e.y, e.err, e.busy, e.rdy);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input logic [7:0] ey, input logic ee,
                             input logic eb, input logic er, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.y    = ey;
        e.err  = ee;
        e.busy = eb;
        e.rdy  = er;
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] cd [3];
        logic [7:0] oh [3];
        cd[0] = 3'd0; cd[1] = 3'd1; cd[2] = 3'd6;
        oh[0] = 8'h01; oh[1] = 8'h02; oh[2] = 8'h40;

        rst_n = 1'b0; en = 1'b0; code_valid = 1'b0; code = '0; done = '0;

        // Reset state, then code_ready follows en even under reset
        step();
        expect_at(0, 8'h00, 0, 0, 0, "rst_state");
        step();
        en = 1'b1;
        expect_at(0, 8'h00, 0, 0, 1, "rst_rdy_en");
        step();

        // T1: code 5, immediate done
        rst_n = 1'b1; code_valid = 1'b1; code = 3'd5;
        expect_at(0, 8'h00, 0, 0, 1, "t1_idle");
        expect_at(1, 8'h20, 0, 1, 0, "t1_grant");
        expect_at(2, 8'h00, 0, 1, 0, "t1_release");
        expect_at(3, 8'h00, 0, 0, 1, "t1_ready_back");
        step(); code_valid = 1'b0; done = 8'h20;
        step(); done = '0;
        step();
        step();

        // T2: code 2, no done -> timeout after 16 grant cycles
        code_valid = 1'b1; code = 3'd2;
        expect_at(0, 8'h00, 0, 0, 1, "t2_idle");
        for (int i = 1; i <= 16; i++) expect_at(i, 8'h04, 0, 1, 0, "t2_hold");
        expect_at(17, 8'h00, 1, 1, 0, "t2_err");
        expect_at(18, 8'h00, 0, 0, 1, "t2_idle_after");
        step(); code_valid = 1'b0;
        repeat (17) step();

        // T3: code 7 with stray done bit 0
        code_valid = 1'b1; code = 3'd7;
        expect_at(1, 8'h80, 0, 1, 0, "t3_grant");
        expect_at(2, 8'h00, 1, 1, 0, "t3_stray_err");
        expect_at(3, 8'h00, 0, 0, 1, "t3_idle");
        step(); code_valid = 1'b0; done = 8'h81;
        step(); done = '0;
        step();

        // T4: code 3, en dropped on 4th grant cycle
        code_valid = 1'b1; code = 3'd3;
        expect_at(0, 8'h00, 0, 0, 1, "t4_idle");
        for (int i = 1; i <= 4; i++) expect_at(i, 8'h08, 0, 1, 0, "t4_hold");
        expect_at(5, 8'h00, 0, 0, 0, "t4_abort");
        expect_at(6, 8'h00, 0, 0, 0, "t4_en_low");
        step(); code_valid = 1'b0;
        step();
        step();
        step(); en = 1'b0;
        step();
        step();
        step(); en = 1'b1;
        expect_at(0, 8'h00, 0, 0, 1, "t4_en_back");

        // T5: code_valid held, codes 0,1,6 back-to-back
        for (int j = 0; j < 3; j++) begin
            expect_at(3 * j,     8'h00, 0, 0, 1, "t5_accept");
            expect_at(3 * j + 1, oh[j], 0, 1, 0, "t5_grant");
            expect_at(3 * j + 2, 8'h00, 0, 1, 0, "t5_release");
        end
        expect_at(9, 8'h00, 0, 0, 1, "t5_idle_end");
        for (int j = 0; j < 3; j++) begin
            code = cd[j]; code_valid = 1'b1;
            step(); done = oh[j];
            step(); done = '0;
            if (j == 2) code_valid = 1'b0;
            step();
        end

        // T6: asynchronous reset mid-grant, then a fresh accept
        code_valid = 1'b1; code = 3'd4;
        expect_at(0, 8'h00, 0, 0, 1, "t6_idle");
        step(); code_valid = 1'b0;
        expect_at(0, 8'h00, 0, 0, 1, "t6_async_rst");
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1; code_valid = 1'b1; code = 3'd6;
        expect_at(0, 8'h00, 0, 0, 1, "t6_post_idle");
        expect_at(1, 8'h40, 0, 1, 0, "t6_post_grant");
        expect_at(2, 8'h00, 0, 1, 0, "t6_post_release");
        expect_at(3, 8'h00, 0, 0, 1, "t6_post_ready");
        step(); code_valid = 1'b0; done = 8'h40;
        step(); done = '0;
        step();
        step();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
